// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg: shared types for the CPU/debug data-memory port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2: two-way round-robin grant with a last-grant register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == PORT_DBG) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (en_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= PORT_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter: shares one data-memory port between CPU and debug loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,
  input  logic              dbg_req_valid,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_req_ready,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  localparam logic [TIMEOUT_W-1:0] TMR_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q;
  logic                 owner_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic                 cpu_rsp_valid_q;
  logic [DATA_W-1:0]    cpu_rsp_rdata_q;
  logic                 cpu_rsp_err_q;
  logic                 dbg_rsp_valid_q;
  logic [DATA_W-1:0]    dbg_rsp_rdata_q;
  logic                 dbg_rsp_err_q;

  logic [1:0]           gnt;
  logic                 can_accept;
  logic                 accept;
  logic                 rsp_fire;
  logic                 rsp_err;
  logic [DATA_W-1:0]    rsp_rdata;

  // Hold off a new grant while a response pulse is on the outputs.
  assign can_accept = !RESET && (state_q == IDLE) && !cpu_rsp_valid_q && !dbg_rsp_valid_q;
  assign accept     = can_accept && (gnt != 2'b00);

  rr_arb2 u_rr_arb2 (
    .CLK   (CLK),
    .RESET (RESET),
    .req_i ({dbg_req_valid, cpu_req_valid}),
    .en_i  (accept),
    .gnt_o (gnt)
  );

  assign rsp_fire  = (state_q == WAIT) && (mem_rsp_valid || (timer_q == TMR_LAST));
  assign rsp_err   = !mem_rsp_valid;
  assign rsp_rdata = (mem_rsp_valid && !we_q) ? mem_rsp_rdata : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      owner_q         <= PORT_CPU;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      timer_q         <= '0;
      cpu_rsp_valid_q <= 1'b0;
      cpu_rsp_rdata_q <= '0;
      cpu_rsp_err_q   <= 1'b0;
      dbg_rsp_valid_q <= 1'b0;
      dbg_rsp_rdata_q <= '0;
      dbg_rsp_err_q   <= 1'b0;
    end else begin
      cpu_rsp_valid_q <= 1'b0;
      cpu_rsp_rdata_q <= '0;
      cpu_rsp_err_q   <= 1'b0;
      dbg_rsp_valid_q <= 1'b0;
      dbg_rsp_rdata_q <= '0;
      dbg_rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= gnt[1];
            we_q    <= gnt[1] ? dbg_req_we    : cpu_req_we;
            addr_q  <= gnt[1] ? dbg_req_addr  : cpu_req_addr;
            wdata_q <= gnt[1] ? dbg_req_wdata : cpu_req_wdata;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_fire) begin
            if (owner_q == PORT_CPU) begin
              cpu_rsp_valid_q <= 1'b1;
              cpu_rsp_rdata_q <= rsp_rdata;
              cpu_rsp_err_q   <= rsp_err;
            end else begin
              dbg_rsp_valid_q <= 1'b1;
              dbg_rsp_rdata_q <= rsp_rdata;
              dbg_rsp_err_q   <= rsp_err;
            end
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TIMEOUT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready = accept && gnt[0];
  assign dbg_req_ready = accept && gnt[1];
  assign cpu_rsp_valid = cpu_rsp_valid_q;
  assign cpu_rsp_rdata = cpu_rsp_rdata_q;
  assign cpu_rsp_err   = cpu_rsp_err_q;
  assign dbg_rsp_valid = dbg_rsp_valid_q;
  assign dbg_rsp_rdata = dbg_rsp_rdata_q;
  assign dbg_rsp_err   = dbg_rsp_err_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule

`default_nettype wire
